// File: rtl/mux_vec_pkg.sv
// Shared types for the mux vector checker: FSM state encoding and vector width helper.
package mux_vec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  function automatic int vec_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

endpackage

// File: rtl/mux_vector_checker_if.sv
// Bundle between the checker, the vector memory and the mux under check, plus the per-vector log.
interface mux_vector_checker_if #(
  parameter int N_VECTORS = 64,
  parameter int IN_W      = 6,
  parameter int OUT_W     = 1
);
  import mux_vec_pkg::*;

  localparam int AW = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
  localparam int VW = vec_w(IN_W, OUT_W);

  logic [AW-1:0]    vecAddr;
  logic [VW-1:0]    vecData;
  logic [IN_W-1:0]  dutIn;
  logic [OUT_W-1:0] dutOut;
  logic             logValid;
  logic [AW-1:0]    logIdx;
  logic             logOk;

  modport master (
    output vecAddr, dutIn, logValid, logIdx, logOk,
    input  vecData, dutOut
  );

  modport slave (
    input  vecAddr, dutIn, logValid, logIdx, logOk,
    output vecData, dutOut
  );

endinterface

// File: rtl/mux_vector_checker.sv
// Walks a packed vector memory, drives each stimulus into the mux, compares its response
// against the expected bits and keeps an error count, first failing index and pass flag.
module mux_vector_checker
  import mux_vec_pkg::*;
#(
  parameter int N_VECTORS     = 64,
  parameter int IN_W          = 6,
  parameter int OUT_W         = 1,
  parameter int SETTLE_CYCLES = 1,
  localparam int AW = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1,
  localparam int CW = $clog2(N_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  mux_vector_checker_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CW-1:0]        errCount_o,
  output logic [AW-1:0]        firstFail_o
);

  localparam int VW = vec_w(IN_W, OUT_W);
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_VECTORS - 1);

  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    vecAddr_q;
  logic [IN_W-1:0]  dutIn_q;
  logic [OUT_W-1:0] exp_q;
  logic [SW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CW-1:0]    errCount_q;
  logic [AW-1:0]    firstFail_q;
  logic             logValid_q;
  logic [AW-1:0]    logIdx_q;
  logic             logOk_q;

  logic [IN_W-1:0]  stim_d;
  logic [OUT_W-1:0] expect_d;
  logic             ok_d;

  // Case-equality so an unknown response is never mistaken for a match.
  always_comb begin
    stim_d   = bus.vecData[VW-1:OUT_W];
    expect_d = bus.vecData[OUT_W-1:0];
    ok_d     = (bus.dutOut === exp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vecAddr_q   <= '0;
      dutIn_q     <= '0;
      exp_q       <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCount_q  <= '0;
      firstFail_q <= '0;
      logValid_q  <= 1'b0;
      logIdx_q    <= '0;
      logOk_q     <= 1'b0;
    end else begin
      logValid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (errCount_q == '0);
          end
          if (start_i) begin
            errCount_q  <= '0;
            firstFail_q <= '0;
            idx_q       <= '0;
            vecAddr_q   <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          vecAddr_q <= idx_q;
          state_q   <= APPLY;
        end
        APPLY: begin
          dutIn_q <= stim_d;
          exp_q   <= expect_d;
          if (SETTLE_CYCLES == 0) begin
            state_q <= CHECK;
          end else begin
            settle_q <= SW'(SETTLE_CYCLES);
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q <= SW'(1)) state_q <= CHECK;
          else settle_q <= settle_q - SW'(1);
        end
        CHECK: begin
          logValid_q <= 1'b1;
          logIdx_q   <= idx_q;
          logOk_q    <= ok_d;
          if (!ok_d) begin
            errCount_q <= errCount_q + CW'(1);
            if (errCount_q == '0) firstFail_q <= idx_q;
          end
          // Address is advanced here so the sync-read memory is already valid in APPLY.
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q     <= idx_q + AW'(1);
            vecAddr_q <= idx_q + AW'(1);
            state_q   <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vecAddr  = vecAddr_q;
  assign bus.dutIn    = dutIn_q;
  assign bus.logValid = logValid_q;
  assign bus.logIdx   = logIdx_q;
  assign bus.logOk    = logOk_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign errCount_o   = errCount_q;
  assign firstFail_o  = firstFail_q;

endmodule

// File: tb/tb_mux_vector_checker.sv
// Directed bench: pairs the checker with a behavioural 4:1 mux and vector ROM, two configurations.
module tb_mux_vector_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic startA, startB;
  logic faultA;

  logic       busyA, doneA, passA;
  logic [6:0] errA;
  logic [5:0] firstA;
  logic       busyB, doneB, passB;
  logic [2:0] errB;
  logic [2:0] firstB;

  logic [6:0] romA [64];
  logic [6:0] romB [8];

  int testCount = 0;
  int failCount = 0;
  int cycle = 0;

  logic [63:0] badMaskA;
  int logCountA, idxErrA;
  int logCountB, maxIdxB, maxAddrB, spacingErrB, lastCycB, badCountB;

  always #5 clk = ~clk;

  mux_vector_checker_if #(.N_VECTORS(64), .IN_W(6), .OUT_W(1)) busA ();
  mux_vector_checker_if #(.N_VECTORS(5),  .IN_W(6), .OUT_W(1)) busB ();

  mux_vector_checker #(.N_VECTORS(64), .IN_W(6), .OUT_W(1), .SETTLE_CYCLES(1)) dutA (
    .clk(clk), .rst_n(rst_n), .start_i(startA), .bus(busA.master),
    .busy_o(busyA), .done_o(doneA), .pass_o(passA), .errCount_o(errA), .firstFail_o(firstA)
  );

  mux_vector_checker #(.N_VECTORS(5), .IN_W(6), .OUT_W(1), .SETTLE_CYCLES(0)) dutB (
    .clk(clk), .rst_n(rst_n), .start_i(startB), .bus(busB.master),
    .busy_o(busyB), .done_o(doneB), .pass_o(passB), .errCount_o(errB), .firstFail_o(firstB)
  );

  // Reference 4:1 mux, stimulus packed {sel1,sel0,a,b,c,d}.
  function automatic logic muxModel(input logic [5:0] s);
    case (s[5:4])
      2'd0:    return s[3];
      2'd1:    return s[2];
      2'd2:    return s[1];
      default: return s[0];
    endcase
  endfunction

  always @(posedge clk) begin
    busA.vecData <= romA[busA.vecAddr];
    busB.vecData <= romB[busB.vecAddr];
    cycle <= cycle + 1;
  end

  assign busA.dutOut = muxModel(busA.dutIn) ^ (faultA && (busA.dutIn == 6'd0));
  assign busB.dutOut = muxModel(busB.dutIn);

  always @(negedge clk) begin
    if (busA.logValid) begin
      if (int'(busA.logIdx) != logCountA) idxErrA++;
      if (!busA.logOk) badMaskA[busA.logIdx] = 1'b1;
      logCountA++;
    end
    if (int'(busB.vecAddr) > maxAddrB) maxAddrB = int'(busB.vecAddr);
    if (busB.logValid) begin
      if (logCountB > 0 && (cycle - lastCycB) != 3) spacingErrB++;
      if (int'(busB.logIdx) > maxIdxB) maxIdxB = int'(busB.logIdx);
      if (!busB.logOk) badCountB++;
      lastCycB = cycle;
      logCountB++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic loadTables();
    for (int i = 0; i < 64; i++) romA[i] = {6'(i), muxModel(6'(i))};
    for (int i = 0; i < 8; i++) romB[i] = {6'(i * 11 + 3), muxModel(6'(i * 11 + 3))};
  endtask

  task automatic clearMonitors();
    badMaskA = '0; logCountA = 0; idxErrA = 0;
    logCountB = 0; maxIdxB = 0; maxAddrB = 0; spacingErrB = 0; lastCycB = 0; badCountB = 0;
  endtask

  // Starts a run and counts edges after the start edge until done rises (bounded).
  task automatic applyStimulus(input bit useB, input int midStart, input bit checkClear,
                               output int cycles);
    if (useB) startB = 1'b1; else startA = 1'b1;
    @(posedge clk);
    #1;
    startA = 1'b0; startB = 1'b0;
    if (checkClear) begin
      checkOutput("restart_err_clear", errA, 0);
      checkOutput("restart_first_clear", firstA, 0);
      checkOutput("restart_done_clear", doneA, 0);
      checkOutput("restart_busy", busyA, 1);
    end
    cycles = 0;
    while (!(useB ? doneB : doneA) && cycles < 1000) begin
      startA = (!useB && cycles == midStart);
      @(posedge clk);
      #1;
      cycles++;
    end
    startA = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; startA = 1'b0; startB = 1'b0; faultA = 1'b0;
    loadTables();
    clearMonitors();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busyA, 0);
    checkOutput("reset_done", doneA, 0);
    checkOutput("reset_pass", passA, 0);
    checkOutput("reset_err", errA, 0);
    checkOutput("reset_addr", busA.vecAddr, 0);
    checkOutput("reset_dutin", busA.dutIn, 0);
    checkOutput("reset_logvalid", busA.logValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] full correct table");
    clearMonitors();
    applyStimulus(1'b0, -1, 1'b0, cyc);
    checkOutput("t1_done_cycle", cyc, 257);
    checkOutput("t1_pass", passA, 1);
    checkOutput("t1_err", errA, 0);
    checkOutput("t1_busy", busyA, 0);
    checkOutput("t1_log_count", logCountA, 64);
    checkOutput("t1_bad_mask", badMaskA, 64'd0);
    checkOutput("t1_log_order", idxErrA, 0);

    $display("[TB] corrupted expected bits at 5 and 40");
    romA[5][0] = ~romA[5][0];
    romA[40][0] = ~romA[40][0];
    clearMonitors();
    applyStimulus(1'b0, -1, 1'b0, cyc);
    checkOutput("t2_done_cycle", cyc, 257);
    checkOutput("t2_err", errA, 2);
    checkOutput("t2_first_fail", firstA, 5);
    checkOutput("t2_bad_mask", badMaskA, (64'd1 << 5) | (64'd1 << 40));
    checkOutput("t2_pass", passA, 0);

    $display("[TB] restart from done with mid-run start pulse");
    loadTables();
    clearMonitors();
    applyStimulus(1'b0, 20, 1'b1, cyc);
    checkOutput("t3_done_cycle", cyc, 257);
    checkOutput("t3_pass", passA, 1);
    checkOutput("t3_err", errA, 0);
    checkOutput("t3_log_count", logCountA, 64);

    $display("[TB] response fault on vector 0");
    faultA = 1'b1;
    clearMonitors();
    applyStimulus(1'b0, -1, 1'b0, cyc);
    faultA = 1'b0;
    checkOutput("t6_err", errA, 1);
    checkOutput("t6_first_fail", firstA, 0);
    checkOutput("t6_bad_mask", badMaskA, 64'd1);
    checkOutput("t6_pass", passA, 0);

    $display("[TB] async reset during settle of vector 10");
    clearMonitors();
    startA = 1'b1;
    @(posedge clk);
    #1;
    startA = 1'b0;
    repeat (42) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_dutin_before", busA.dutIn, 10);
    checkOutput("t4_logidx_before", busA.logIdx, 9);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_busy", busyA, 0);
    checkOutput("t4_done", doneA, 0);
    checkOutput("t4_err", errA, 0);
    checkOutput("t4_dutin", busA.dutIn, 0);
    checkOutput("t4_addr", busA.vecAddr, 0);
    checkOutput("t4_logidx", busA.logIdx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_idle_busy", busyA, 0);
    checkOutput("t4_idle_done", doneA, 0);
    checkOutput("t4_log_count", logCountA, 10);
    @(negedge clk);

    $display("[TB] five vectors, no settle cycles");
    clearMonitors();
    applyStimulus(1'b1, -1, 1'b0, cyc);
    checkOutput("t5_done_cycle", cyc, 16);
    checkOutput("t5_log_count", logCountB, 5);
    checkOutput("t5_max_idx", maxIdxB, 4);
    checkOutput("t5_max_addr", maxAddrB, 4);
    checkOutput("t5_spacing", spacingErrB, 0);
    checkOutput("t5_bad", badCountB, 0);
    checkOutput("t5_pass", passB, 1);
    checkOutput("t5_err", errB, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
